uart_rx_deser_frame: RTL and testbench

// Parametrised UART RX deserializer, successor to the fixed 8-bit shifter. Sits between the
// RX FSM/edge counter and the parity/stop checkers. Collects a frame of 5..MAX_WIDTH data

---
 rtl/uart_rx_deser_frame.sv | 117 +++++++++++
 tb/tb_uart_rx_deser_frame.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser_frame.sv
// uart_rx_deser_frame: collects 5..MAX_WIDTH UART data bits plus optional parity into a right-aligned word
module uart_rx_deser_frame #(
    parameter int MAX_WIDTH = 9,
    parameter int CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 deser_en,
    input  logic                 sampled_bit,
    input  logic [CNT_W-1:0]     edge_cnt,
    input  logic [CNT_W-1:0]     prescale,
    input  logic [3:0]           data_len,
    input  logic                 msb_first,
    input  logic                 par_en,
    input  logic                 par_type,
    output logic [MAX_WIDTH-1:0] p_data,
    output logic                 data_valid,
    output logic                 par_err,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;
    localparam logic [3:0] MAX_LEN = 4'(MAX_WIDTH);
    state_t               state_q, state_d;
    logic [3:0]           len_q, len_d, bit_cnt_q, bit_cnt_d;
    logic                 msb_q, msb_d, pen_q, pen_d, ptype_q, ptype_d;
    logic                 par_acc_q, par_acc_d, rx_par_q, rx_par_d;
    logic [MAX_WIDTH-1:0] shreg_q, shreg_d, p_data_q, p_data_d;
    logic                 data_valid_q, data_valid_d, par_err_q, par_err_d, busy_q, busy_d;
    logic [CNT_W-1:0]     last_edge;
    logic                 strobe;
    logic [3:0]           len_clamp;
    always_comb begin
        last_edge    = prescale - CNT_W'(1);
        strobe       = deser_en && (edge_cnt == last_edge);
        len_clamp    = (data_len < 4'd5) ? 4'd5 : (data_len > MAX_LEN) ? MAX_LEN : data_len;
        state_d      = state_q;
        len_d        = len_q;
        bit_cnt_d    = bit_cnt_q;
        msb_d        = msb_q;
        pen_d        = pen_q;
        ptype_d      = ptype_q;
        par_acc_d    = par_acc_q;
        rx_par_d     = rx_par_q;
        shreg_d      = shreg_q;
        // The DONE cycle always publishes, even if a new frame_start arrives in it
        data_valid_d = state_q == DONE;
        p_data_d     = data_valid_d ? shreg_q : p_data_q;
        par_err_d    = data_valid_d ? (pen_q & ((par_acc_q ^ ptype_q) != rx_par_q)) : par_err_q;
        if (frame_start) begin
            state_d   = DATA;
            bit_cnt_d = 4'd0;
            shreg_d   = '0;
            par_acc_d = 1'b0;
            rx_par_d  = 1'b0;
            len_d     = len_clamp;
            msb_d     = msb_first;
            pen_d     = par_en;
            ptype_d   = par_type;
        end else begin
            case (state_q)
                IDLE: ;
                DATA: if (strobe) begin
                    if (msb_q)
                        shreg_d = {shreg_q[MAX_WIDTH-2:0], sampled_bit};
                    else
                        shreg_d[bit_cnt_q] = sampled_bit;
                    par_acc_d = par_acc_q ^ sampled_bit;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == len_q - 4'd1)
                        state_d = pen_q ? PARITY : DONE;
                end
                PARITY: if (strobe) begin
                    rx_par_d = sampled_bit;
                    state_d  = DONE;
                end
                DONE: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == DATA) || (state_d == PARITY);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= 4'd5;
            bit_cnt_q    <= 4'd0;
            msb_q        <= 1'b0;
            pen_q        <= 1'b0;
            ptype_q      <= 1'b0;
            par_acc_q    <= 1'b0;
            rx_par_q     <= 1'b0;
            shreg_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            bit_cnt_q    <= bit_cnt_d;
            msb_q        <= msb_d;
            pen_q        <= pen_d;
            ptype_q      <= ptype_d;
            par_acc_q    <= par_acc_d;
            rx_par_q     <= rx_par_d;
            shreg_q      <= shreg_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            busy_q       <= busy_d;
        end
    end
    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_deser_frame.sv
// tb_uart_rx_deser_frame: table vectors, corner sequences and random frames against a bit-list reference model
module tb_uart_rx_deser_frame;
    localparam int MW = 9;
    localparam int CW = 6;
    logic          clk = 1'b0;
    logic          rst, frame_start, deser_en, sampled_bit, msb_first, par_en, par_type;
    logic [CW-1:0] edge_cnt, prescale;
    logic [3:0]    data_len;
    logic [MW-1:0] p_data;
    logic          data_valid, par_err, busy;
    int            n_chk = 0, n_fail = 0, valid_cnt = 0, dbl_cnt = 0, vc;
    logic          dv_prev = 1'b0;

    typedef struct {
        logic [3:0]    len;
        logic          msb, pen, ptype;
        logic [MW-1:0] bits;
        int            n;
        logic          parbit;
        logic [MW-1:0] exp_d;
        logic          exp_e;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    uart_rx_deser_frame #(.MAX_WIDTH(MW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .deser_en(deser_en),
        .sampled_bit(sampled_bit), .edge_cnt(edge_cnt), .prescale(prescale),
        .data_len(data_len), .msb_first(msb_first), .par_en(par_en), .par_type(par_type),
        .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .busy(busy)
    );

    always @(negedge clk) begin
        if (data_valid) begin
            valid_cnt <= valid_cnt + 1;
            if (dv_prev) dbl_cnt <= dbl_cnt + 1;
        end
        dv_prev <= data_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Strobe point is the edge just before wrap of prescale; prescale 0 means all ones.
    function automatic logic [CW-1:0] strobe_edge();
        return (prescale == '0) ? {CW{1'b1}} : prescale - CW'(1);
    endfunction

    task automatic scramble_cfg;
        data_len  = 4'($urandom);
        msb_first = 1'($urandom);
        par_en    = 1'($urandom);
        par_type  = 1'($urandom);
    endtask

    task automatic send_bit(input logic b);
        int gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            deser_en    = 1'($urandom);
            edge_cnt    = strobe_edge() + CW'($urandom_range(1, 3));
            sampled_bit = 1'($urandom);
            scramble_cfg();
            tick();
        end
        deser_en    = 1'b1;
        edge_cnt    = strobe_edge();
        sampled_bit = b;
        tick();
        deser_en    = 1'b0;
        sampled_bit = ~b;
    endtask

    task automatic start(input logic [3:0] len, input logic msb, input logic pen, input logic ptype);
        data_len    = len;
        msb_first   = msb;
        par_en      = pen;
        par_type    = ptype;
        frame_start = 1'b1;
        deser_en    = 1'b1;
        edge_cnt    = strobe_edge();
        sampled_bit = 1'b1;
        tick();
        frame_start = 1'b0;
        deser_en    = 1'b0;
        scramble_cfg();
    endtask

    task automatic send_frame(input logic [3:0] len, input logic msb, input logic pen, input logic ptype,
                              input logic [MW-1:0] bits, input int n, input logic parbit);
        start(len, msb, pen, ptype);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
        if (pen) send_bit(parbit);
    endtask

    task automatic expect_frame(input logic [MW-1:0] exp_d, input logic exp_e, input string name);
        check({name, " valid_early"}, data_valid, 0);
        tick();
        check({name, " valid"}, data_valid, 1);
        check({name, " p_data"}, p_data, exp_d);
        check({name, " par_err"}, par_err, exp_e);
        tick();
        check({name, " valid_drop"}, data_valid, 0);
        check({name, " busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; deser_en = 1'b0; sampled_bit = 1'b0;
        edge_cnt = '0; prescale = 6'd8; data_len = 4'd8;
        msb_first = 1'b0; par_en = 1'b0; par_type = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset p_data", p_data, 0);
        check("reset valid", data_valid, 0);
        check("reset par_err", par_err, 0);
        check("reset busy", busy, 0);

        vecs[0] = '{4'd8,  1'b0, 1'b0, 1'b0, 9'h0A5, 8, 1'b0, 9'h0A5, 1'b0};
        vecs[1] = '{4'd8,  1'b1, 1'b0, 1'b0, 9'h0A5, 8, 1'b0, 9'h0A5, 1'b0};
        vecs[2] = '{4'd7,  1'b0, 1'b1, 1'b0, 9'h041, 7, 1'b0, 9'h041, 1'b0};
        vecs[3] = '{4'd7,  1'b0, 1'b1, 1'b0, 9'h041, 7, 1'b1, 9'h041, 1'b1};
        vecs[4] = '{4'd7,  1'b0, 1'b1, 1'b1, 9'h041, 7, 1'b1, 9'h041, 1'b0};
        vecs[5] = '{4'd9,  1'b0, 1'b0, 1'b0, 9'h1FF, 9, 1'b0, 9'h1FF, 1'b0};
        vecs[6] = '{4'd3,  1'b0, 1'b0, 1'b0, 9'h01F, 5, 1'b0, 9'h01F, 1'b0};
        vecs[7] = '{4'd15, 1'b0, 1'b0, 1'b0, 9'h155, 9, 1'b0, 9'h155, 1'b0};
        vecs[8] = '{4'd5,  1'b1, 1'b1, 1'b1, 9'h013, 5, 1'b1, 9'h019, 1'b1};
        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].len, vecs[v].msb, vecs[v].pen, vecs[v].ptype, vecs[v].bits, vecs[v].n, vecs[v].parbit);
            expect_frame(vecs[v].exp_d, vecs[v].exp_e, $sformatf("vec%0d", v));
        end

        start(4'd8, 1'b0, 1'b1, 1'b0);
        check("restart busy", busy, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        vc = valid_cnt;
        send_frame(4'd8, 1'b0, 1'b1, 1'b0, 9'h03C, 8, 1'b1);
        expect_frame(9'h03C, 1'b1, "restart");
        check("restart single valid", valid_cnt, vc + 1);

        start(4'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst p_data", p_data, 0);
        check("midrst par_err", par_err, 0);
        check("midrst valid", data_valid, 0);
        check("midrst busy", busy, 0);
        vc = valid_cnt;
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        tick(); tick();
        check("midrst no valid", valid_cnt, vc);
        check("midrst p_data hold", p_data, 0);

        start(4'd5, 1'b0, 1'b0, 1'b0);
        deser_en = 1'b0; edge_cnt = strobe_edge(); sampled_bit = 1'b1;
        tick();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        expect_frame(9'h00A, 1'b0, "gated");

        vc = valid_cnt;
        for (int i = 0; i < 6; i++) send_bit(1'($urandom));
        tick();
        check("idle p_data", p_data, 9'h00A);
        check("idle no valid", valid_cnt, vc);
        check("idle busy", busy, 0);

        prescale = '0;
        send_frame(4'd5, 1'b0, 1'b0, 1'b0, 9'h016, 5, 1'b0);
        expect_frame(9'h016, 1'b0, "prescale0");

        for (int r = 0; r < 40; r++) begin
            logic [3:0]    len;
            logic          msb, pen, ptype, parbit;
            logic [MW-1:0] bits, mask, exp_d;
            int            n, ones;
            len = 4'($urandom); msb = 1'($urandom); pen = 1'($urandom);
            ptype = 1'($urandom); parbit = 1'($urandom); bits = MW'($urandom);
            prescale = CW'($urandom_range(0, 63));
            n = (len < 5) ? 5 : (len > MW) ? MW : int'(len);
            mask = MW'((1 << n) - 1);
            exp_d = '0;
            for (int i = 0; i < n; i++)
                if (bits[i]) exp_d = exp_d + MW'(msb ? (1 << (n - 1 - i)) : (1 << i));
            ones = $countones(bits & mask);
            send_frame(len, msb, pen, ptype, bits, n, parbit);
            expect_frame(exp_d, pen && (((ones + int'(ptype) + int'(parbit)) % 2) == 1), $sformatf("rand%0d", r));
        end

        check("no double valid", dbl_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
